// File: rtl/draw_pkg.sv
// Shared defaults, mode encodings and controller states for the rectangle drawer.
package draw_pkg;
  localparam int DEF_COORD_W  = 10;
  localparam int DEF_COL_W    = 3;
  localparam int DEF_SCREEN_W = 160;
  localparam int DEF_SCREEN_H = 120;

  typedef enum logic [1:0] {
    MODE_FILL    = 2'b00,
    MODE_OUTLINE = 2'b01,
    MODE_ERASE   = 2'b10,
    MODE_RSVD    = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_DRAW = 2'b01,
    S_DONE = 2'b10
  } state_t;
endpackage

// File: rtl/rect_draw_ctrl.sv
// Sequencing FSM for rect_draw: accepts a request, tracks the scan, pulses done.
module rect_draw_ctrl
  import draw_pkg::*;
(
  input  logic   clk,
  input  logic   resetn,
  input  logic   start,
  input  logic   zero_size,
  input  logic   last,
  output state_t state,
  output logic   busy,
  output logic   done
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= S_IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            busy <= 1'b1;
            // Degenerate rectangles skip the scan entirely.
            if (zero_size) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_DRAW;
            end
          end
        end
        S_DRAW: begin
          if (last) begin
            state <= S_DONE;
            done  <= 1'b1;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/rect_draw.sv
// Rectangle rasteriser: column-major scan, screen clipping, fill/outline/erase,
// one registered pixel write per cycle.
module rect_draw
  import draw_pkg::*;
#(
  parameter int COORD_W  = DEF_COORD_W,
  parameter int COL_W    = DEF_COL_W,
  parameter int SCREEN_W = DEF_SCREEN_W,
  parameter int SCREEN_H = DEF_SCREEN_H
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  input  logic [COORD_W-1:0] w_in,
  input  logic [COORD_W-1:0] h_in,
  input  logic [COL_W-1:0]   colour_in,
  input  logic [1:0]         mode,
  output logic               writeEn,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic [COL_W-1:0]   colour,
  output logic               busy,
  output logic               done
);

  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
  localparam logic [COORD_W:0]   LIM_X = (COORD_W+1)'(SCREEN_W);
  localparam logic [COORD_W:0]   LIM_Y = (COORD_W+1)'(SCREEN_H);

  state_t             state;
  logic [COORD_W-1:0] cap_x, cap_y, cap_w, cap_h;
  logic [COL_W-1:0]   cap_col;
  mode_t              cap_mode;
  logic [COORD_W-1:0] cx, cy;

  logic               is_idle, is_draw, zero_size, last, load, step;
  logic [COORD_W-1:0] src_x, src_y, src_w, src_h;
  logic [COL_W-1:0]   src_col;
  mode_t              src_mode;
  logic [COORD_W-1:0] nx_cx, nx_cy;
  logic [COORD_W:0]   sum_x, sum_y;
  logic               border, pix_we;
  logic [COL_W-1:0]   pix_col;

  function automatic logic on_screen(input logic [COORD_W:0] sx, input logic [COORD_W:0] sy);
    return (sx < LIM_X) && (sy < LIM_Y);
  endfunction

  rect_draw_ctrl u_ctrl (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .zero_size (zero_size),
    .last      (last),
    .state     (state),
    .busy      (busy),
    .done      (done)
  );

  assign is_idle   = (state == S_IDLE);
  assign is_draw   = (state == S_DRAW);
  assign zero_size = (w_in == '0) || (h_in == '0);
  assign last      = is_draw && (cx == cap_w - ONE) && (cy == cap_h - ONE);
  assign load      = is_idle && start && !zero_size;
  assign step      = is_draw && !last;

  // The first pixel is issued on the accepting edge, so it is built from the live inputs.
  always_comb begin
    src_x    = is_idle ? x_in : cap_x;
    src_y    = is_idle ? y_in : cap_y;
    src_w    = is_idle ? w_in : cap_w;
    src_h    = is_idle ? h_in : cap_h;
    src_col  = is_idle ? colour_in : cap_col;
    src_mode = is_idle ? mode_t'(mode) : cap_mode;

    nx_cx = cx;
    nx_cy = cy;
    if (load) begin
      nx_cx = '0;
      nx_cy = '0;
    end else if (step) begin
      if (cy == cap_h - ONE) begin
        nx_cx = cx + ONE;
        nx_cy = '0;
      end else begin
        nx_cy = cy + ONE;
      end
    end

    sum_x  = {1'b0, src_x} + {1'b0, nx_cx};
    sum_y  = {1'b0, src_y} + {1'b0, nx_cy};
    border = (nx_cx == '0) || (nx_cx == src_w - ONE) ||
             (nx_cy == '0) || (nx_cy == src_h - ONE);
    pix_we  = on_screen(sum_x, sum_y) && ((src_mode != MODE_OUTLINE) || border);
    pix_col = (src_mode == MODE_ERASE) ? '0 : src_col;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_x    <= '0;
      cap_y    <= '0;
      cap_w    <= '0;
      cap_h    <= '0;
      cap_col  <= '0;
      cap_mode <= MODE_FILL;
      cx       <= '0;
      cy       <= '0;
      writeEn  <= 1'b0;
      x_out    <= '0;
      y_out    <= '0;
      colour   <= '0;
    end else begin
      if (is_idle && start) begin
        cap_x    <= x_in;
        cap_y    <= y_in;
        cap_w    <= w_in;
        cap_h    <= h_in;
        cap_col  <= colour_in;
        cap_mode <= mode_t'(mode);
      end
      // Output stage: pixel coordinate, colour and strobe leave together.
      if (load || step) begin
        cx      <= nx_cx;
        cy      <= nx_cy;
        writeEn <= pix_we;
        x_out   <= sum_x[COORD_W-1:0];
        y_out   <= sum_y[COORD_W-1:0];
        colour  <= pix_col;
      end else begin
        writeEn <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rect_draw.sv
// Randomised scoreboard bench for rect_draw against a pixel-list reference model.
module tb_rect_draw;
  logic       clk = 1'b0;
  logic       resetn;
  logic       start;
  logic [9:0] x_in, y_in, w_in, h_in;
  logic [2:0] colour_in;
  logic [1:0] mode;
  logic       writeEn;
  logic [9:0] x_out, y_out;
  logic [2:0] colour;
  logic       busy, done;

  rect_draw dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .x_in      (x_in),
    .y_in      (y_in),
    .w_in      (w_in),
    .h_in      (h_in),
    .colour_in (colour_in),
    .mode      (mode),
    .writeEn   (writeEn),
    .x_out     (x_out),
    .y_out     (y_out),
    .colour    (colour),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int x;
    int y;
    int col;
  } pix_t;

  pix_t wq[$];
  int   dq[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;
  int   wr_seen = 0;
  int   wr_exp = 0;
  pix_t mon_p;

  task automatic chk(input string name, input longint act, input longint exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: enumerate every pixel of the rectangle in scan order and keep the visible ones.
  task automatic model(input int x, input int y, input int w, input int h,
                       input int col, input int md, input int k);
    int idx = 0;
    wr_exp = 0;
    for (int i = 0; i < w; i++) begin
      for (int j = 0; j < h; j++) begin
        int sx = x + i;
        int sy = y + j;
        bit edge_px = (i == 0) || (i == w - 1) || (j == 0) || (j == h - 1);
        if (sx < 160 && sy < 120 && (md != 1 || edge_px)) begin
          pix_t p;
          p.cyc = k + idx;
          p.x   = sx % 1024;
          p.y   = sy % 1024;
          p.col = (md == 2) ? 0 : col;
          wq.push_back(p);
          wr_exp++;
        end
        idx++;
      end
    end
    dq.push_back((w == 0 || h == 0) ? k : k + w * h);
  endtask

  task automatic scramble();
    x_in      = 10'($urandom);
    y_in      = 10'($urandom);
    w_in      = 10'($urandom);
    h_in      = 10'($urandom);
    colour_in = 3'($urandom);
    mode      = 2'($urandom);
  endtask

  task automatic issue(input int x, input int y, input int w, input int h,
                       input int col, input int md);
    @(negedge clk);
    x_in = 10'(x); y_in = 10'(y); w_in = 10'(w); h_in = 10'(h);
    colour_in = 3'(col); mode = 2'(md);
    start = 1'b1;
    wr_seen = 0;
    model(x, y, w, h, col, md, cyc + 1);
    @(negedge clk);
    start = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk("busy_timeout", busy, 0);
  endtask

  task automatic run(input int x, input int y, input int w, input int h,
                     input int col, input int md, input bit spurious);
    issue(x, y, w, h, col, md);
    if (spurious) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (busy) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
    end
    wait_idle();
    chk("writes_left", wq.size(), 0);
    chk("done_left", dq.size(), 0);
    chk("write_count", wr_seen, wr_exp);
  endtask

  always @(negedge clk) begin
    if (resetn) begin
      if (writeEn) begin
        wr_seen++;
        chk("write_queued", wq.size() != 0, 1);
        if (wq.size() != 0) begin
          mon_p = wq.pop_front();
          chk("pix_cycle", cyc, mon_p.cyc);
          chk("pix_x", x_out, mon_p.x);
          chk("pix_y", y_out, mon_p.y);
          chk("pix_colour", colour, mon_p.col);
        end
      end
      if (done) begin
        chk("done_queued", dq.size() != 0, 1);
        if (dq.size() != 0) chk("done_cycle", cyc, dq.pop_front());
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    resetn = 1'b0;
    start  = 1'b0;
    scramble();
    repeat (3) @(negedge clk);
    chk("rst_writeEn", writeEn, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_x_out", x_out, 0);
    chk("rst_y_out", y_out, 0);
    chk("rst_colour", colour, 0);
    resetn = 1'b1;
    repeat (2) @(negedge clk);

    run(10, 20, 3, 2, 5, 0, 1'b0);
    run(0, 0, 4, 4, 3, 1, 1'b0);
    run(158, 118, 4, 4, 6, 0, 1'b0);
    run(5, 5, 2, 2, 7, 2, 1'b1);
    run(40, 50, 3, 3, 4, 3, 1'b0);

    // Zero-width request: busy only in the done cycle.
    issue(12, 12, 0, 5, 2, 0);
    chk("zero_busy_on", busy, 1);
    @(negedge clk);
    chk("zero_busy_off", busy, 0);
    chk("zero_writes", wr_seen, 0);
    chk("zero_done_left", dq.size(), 0);

    // Abort a 10x10 fill while its third pixel is on the outputs.
    issue(30, 40, 10, 10, 6, 0);
    repeat (2) @(negedge clk);
    #1 resetn = 1'b0;
    #1;
    chk("abort_writeEn", writeEn, 0);
    chk("abort_x_out", x_out, 0);
    chk("abort_y_out", y_out, 0);
    chk("abort_colour", colour, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    wq.delete();
    dq.delete();
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    repeat (4) @(negedge clk);
    run(30, 40, 10, 10, 6, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int x = ($urandom_range(0, 7) == 0) ? $urandom_range(1015, 1023) : $urandom_range(0, 175);
      int y = ($urandom_range(0, 7) == 0) ? $urandom_range(1015, 1023) : $urandom_range(0, 130);
      run(x, y, $urandom_range(0, 12), $urandom_range(0, 12),
          $urandom_range(0, 7), $urandom_range(0, 3), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
